regfile_bypass_stage: RTL

//  Parametrised multi-port register file with a registered read stage. It feeds
//  the SPU even and odd pipes and generalises the fixed 128x128 file to
//  NUM_RD read ports and NUM_WR write-back ports. Adds same-cycle write->read

---
 rtl/regfile_bypass_if.sv | 29 ++
 rtl/regfile_bypass_stage.sv | 81 ++++++++
 2 files changed

// File: rtl/regfile_bypass_if.sv
// Read/write bundle between the register file stage and its clients.
// Write-back ports, read request, pipeline control and registered operands.
interface regfile_bypass_if #(
    parameter int WIDTH  = 128,
    parameter int AW     = 7,
    parameter int NUM_RD = 6,
    parameter int NUM_WR = 2
);
    logic [NUM_WR-1:0]       wr_en;
    logic [NUM_WR*AW-1:0]    wr_addr;
    logic [NUM_WR*WIDTH-1:0] wr_data;
    logic                    rd_valid_in;
    logic [NUM_RD*AW-1:0]    rd_addr;
    logic                    stall;
    logic                    flush;
    logic                    rd_valid_out;
    logic [NUM_RD*WIDTH-1:0] rd_data;
    logic [NUM_RD*AW-1:0]    rd_addr_out;

    modport master (
        output wr_en, wr_addr, wr_data, rd_valid_in, rd_addr, stall, flush,
        input  rd_valid_out, rd_data, rd_addr_out
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_valid_in, rd_addr, stall, flush,
        output rd_valid_out, rd_data, rd_addr_out
    );
endinterface

// File: rtl/regfile_bypass_stage.sv
// Multi-port register file with write->read bypass and a registered read
// stage supporting stall (with held-operand refresh) and flush.
module regfile_bypass_stage #(
    parameter int WIDTH  = 128,
    parameter int DEPTH  = 128,
    parameter int AW     = $clog2(DEPTH),
    parameter int NUM_RD = 6,
    parameter int NUM_WR = 2
) (
    input logic           clk,
    input logic           rst,
    regfile_bypass_if.slave bus
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0]        mem [DEPTH];
    logic [WIDTH-1:0]        fwd [NUM_RD];
    logic [WIDTH-1:0]        held [NUM_RD];
    logic                    valid_q;
    logic [NUM_RD*WIDTH-1:0] data_q;
    logic [NUM_RD*AW-1:0]    addr_q;
    logic [AW-1:0]           ra;
    logic [AW-1:0]           ha;
    logic [AW-1:0]           wa;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    assign bus.rd_valid_out = valid_q;
    assign bus.rd_data      = data_q;
    assign bus.rd_addr_out  = addr_q;

    // Ascending port scan: the last matching write port overrides earlier ones.
    always_comb begin
        ra = '0;
        ha = '0;
        wa = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            ra      = bus.rd_addr[j*AW +: AW];
            ha      = addr_q[j*AW +: AW];
            fwd[j]  = in_range(ra) ? mem[ra] : '0;
            held[j] = data_q[j*WIDTH +: WIDTH];
            for (int k = 0; k < NUM_WR; k++) begin
                wa = bus.wr_addr[k*AW +: AW];
                if (bus.wr_en[k] && in_range(ra) && wa == ra)
                    fwd[j] = bus.wr_data[k*WIDTH +: WIDTH];
                if (bus.wr_en[k] && wa == ha)
                    held[j] = bus.wr_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (bus.wr_en[k] && in_range(bus.wr_addr[k*AW +: AW]))
                    mem[bus.wr_addr[k*AW +: AW]] <= bus.wr_data[k*WIDTH +: WIDTH];
            end
            if (bus.flush) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                addr_q  <= '0;
            end else if (bus.stall) begin
                for (int j = 0; j < NUM_RD; j++)
                    data_q[j*WIDTH +: WIDTH] <= held[j];
            end else begin
                valid_q <= bus.rd_valid_in;
                addr_q  <= bus.rd_addr;
                for (int j = 0; j < NUM_RD; j++)
                    data_q[j*WIDTH +: WIDTH] <= fwd[j];
            end
        end
    end
endmodule
